// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// The optional perf counters in the top level are enabled by defining HAZARD_PERF_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard for long-latency ops whose results return out of band.
// Tracks one pending bit per register plus the number of outstanding ops.
module hazard_scoreboard #(
  parameter  int REG_AW          = 5,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int NUM_REGS        = 2**REG_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_valid,
  input  logic [REG_AW-1:0]   set_rd,
  input  logic                clr_valid,
  input  logic [REG_AW-1:0]   clr_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                sb_full
);
  import hazard_pkg::*;

  localparam int                CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                do_set, do_clr;

  // Set is applied after clear so a same-register return/issue leaves the bit set.
  always_comb begin
    do_set    = set_valid && (set_rd != ZERO_IDX);
    do_clr    = clr_valid && pending_q[clr_rd];
    pending_d = pending_q;
    count_d   = count_q;
    if (do_clr) pending_d[clr_rd] = 1'b0;
    if (do_set) pending_d[set_rd] = 1'b1;
    pending_d[REG_ZERO] = 1'b0;
    if (do_set && !do_clr)
      count_d = count_q + CNT_W'(1);
    else if (do_clr && !do_set)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign pending = pending_q;
  assign sb_full = (count_q == CNT_MAX);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the 5-stage pipeline.
// Define HAZARD_PERF_EN to build the stall-cycle and forward-event perf counters.
module hazard_forward_unit #(
  parameter  int REG_AW          = 5,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int STALL_TIMEOUT   = 256,
  localparam int NUM_REGS        = 2**REG_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_regwrite,
  input  logic                id_long,
  input  logic                ex_valid,
  input  logic [REG_AW-1:0]   ex_rs1,
  input  logic [REG_AW-1:0]   ex_rs2,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_use_rs1,
  input  logic                ex_use_rs2,
  input  logic                ex_regwrite,
  input  logic                ex_long,
  input  logic                ex_adv,
  input  logic                flush,
  input  logic                mem_valid,
  input  logic                mem_regwrite,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic                wb_valid,
  input  logic                wb_regwrite,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                lr_valid,
  input  logic [REG_AW-1:0]   lr_rd,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic                stall_id,
  output logic                sb_full,
  output logic                timeout_err,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [31:0]         perf_stall_cycles,
  output logic [31:0]         perf_fwd_events
);
  import hazard_pkg::*;

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);
  localparam int                TO_W     = $clog2(STALL_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(STALL_TIMEOUT);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(STALL_TIMEOUT - 1);

  function automatic fwd_sel_e fwd_select(
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic              m_valid,
    input logic              m_wr,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_valid,
    input logic              w_wr,
    input logic [REG_AW-1:0] w_rd
  );
    if (use_rs && m_valid && m_wr && (m_rd != ZERO_IDX) && (m_rd == rs))
      return FWD_MEM;
    else if (use_rs && w_valid && w_wr && (w_rd != ZERO_IDX) && (w_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  fwd_sel_e            fwd_a, fwd_b;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] busy;
  logic                ex_long_wr;
  logic                sb_set;
  logic [TO_W-1:0]     stall_cnt;

  always_comb begin
    fwd_a = fwd_select(ex_use_rs1, ex_rs1, mem_valid, mem_regwrite, mem_rd,
                       wb_valid, wb_regwrite, wb_rd);
    fwd_b = fwd_select(ex_use_rs2, ex_rs2, mem_valid, mem_regwrite, mem_rd,
                       wb_valid, wb_regwrite, wb_rd);
  end

  assign forward_a = fwd_a;
  assign forward_b = fwd_b;

  assign ex_long_wr = ex_valid && ex_long && ex_regwrite;
  assign sb_set     = ex_long_wr && ex_adv && !flush;

  hazard_scoreboard #(
    .REG_AW          (REG_AW),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (sb_set),
    .set_rd    (ex_rd),
    .clr_valid (lr_valid),
    .clr_rd    (lr_rd),
    .pending   (pending),
    .sb_full   (sb_full)
  );

  // A result returning this cycle is already in the write-through regfile,
  // while a long op still sitting in EX is not yet on the scoreboard.
  always_comb begin
    busy = pending;
    if (lr_valid)   busy[lr_rd] = 1'b0;
    if (ex_long_wr) busy[ex_rd] = 1'b1;
    busy[REG_ZERO] = 1'b0;
  end

  assign stall_id = id_valid && ((id_use_rs1  && busy[id_rs1]) ||
                                 (id_use_rs2  && busy[id_rs2]) ||
                                 (id_regwrite && busy[id_rd])  ||
                                 (id_long     && sb_full));

  assign pending_mask = pending;

  // The error flag rises on the same edge the counter reaches the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else if (stall_id) begin
      if (stall_cnt != TO_MAX) stall_cnt <= stall_cnt + TO_W'(1);
      if (stall_cnt == TO_LAST) timeout_err <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, fwd_events_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      if (stall_id) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (ex_valid && ((fwd_a != FWD_RF) || (fwd_b != FWD_RF)))
        fwd_events_q <= fwd_events_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cycles_q;
  assign perf_fwd_events   = fwd_events_q;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_fwd_events   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit (default parameters).
// Perf-counter expectations follow HAZARD_PERF_EN as seen by this compile.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_long;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_valid, ex_use_rs1, ex_use_rs2, ex_regwrite, ex_long, ex_adv, flush;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        mem_valid, mem_regwrite, wb_valid, wb_regwrite, lr_valid;
  logic [4:0]  mem_rd, wb_rd, lr_rd;
  logic [1:0]  forward_a, forward_b;
  logic        stall_id, sb_full, timeout_err;
  logic [31:0] pending_mask, perf_stall_cycles, perf_fwd_events;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .id_rd             (id_rd),
    .id_use_rs1        (id_use_rs1),
    .id_use_rs2        (id_use_rs2),
    .id_regwrite       (id_regwrite),
    .id_long           (id_long),
    .ex_valid          (ex_valid),
    .ex_rs1            (ex_rs1),
    .ex_rs2            (ex_rs2),
    .ex_rd             (ex_rd),
    .ex_use_rs1        (ex_use_rs1),
    .ex_use_rs2        (ex_use_rs2),
    .ex_regwrite       (ex_regwrite),
    .ex_long           (ex_long),
    .ex_adv            (ex_adv),
    .flush             (flush),
    .mem_valid         (mem_valid),
    .mem_regwrite      (mem_regwrite),
    .mem_rd            (mem_rd),
    .wb_valid          (wb_valid),
    .wb_regwrite       (wb_regwrite),
    .wb_rd             (wb_rd),
    .lr_valid          (lr_valid),
    .lr_rd             (lr_rd),
    .forward_a         (forward_a),
    .forward_b         (forward_b),
    .stall_id          (stall_id),
    .sb_full           (sb_full),
    .timeout_err       (timeout_err),
    .pending_mask      (pending_mask),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_fwd_events   (perf_fwd_events)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 2 time units after the rising edge, well clear of it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clearInputs();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_long = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    ex_valid = 0; ex_use_rs1 = 0; ex_use_rs2 = 0; ex_regwrite = 0; ex_long = 0;
    ex_adv = 0; flush = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    mem_valid = 0; mem_regwrite = 0; mem_rd = 0;
    wb_valid = 0; wb_regwrite = 0; wb_rd = 0;
    lr_valid = 0; lr_rd = 0;
  endtask

  // Issue one long-latency op out of EX for a single cycle.
  task automatic applyStimulus(input logic [4:0] rd, input logic do_flush);
    ex_valid = 1; ex_adv = 1; ex_long = 1; ex_regwrite = 1; ex_rd = rd; flush = do_flush;
    step();
    ex_valid = 0; ex_adv = 0; ex_long = 0; ex_regwrite = 0; ex_rd = 0; flush = 0;
    #1;
  endtask

  initial begin
    rst = 1;
    clearInputs();
    #3;
    checkOutput("reset_pending", pending_mask, 32'h0);
    checkOutput("reset_sb_full", {31'b0, sb_full}, 32'h0);
    checkOutput("reset_timeout", {31'b0, timeout_err}, 32'h0);
    checkOutput("reset_stall", {31'b0, stall_id}, 32'h0);
    checkOutput("reset_perf_stall", perf_stall_cycles, 32'h0);
    checkOutput("reset_perf_fwd", perf_fwd_events, 32'h0);
    step();
    rst = 0;

    // Forwarding priority on rs1
    $display("[TB] forwarding");
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 5;
    ex_valid = 1; ex_use_rs1 = 1; ex_rs1 = 5; ex_use_rs2 = 1; ex_rs2 = 6;
    #1;
    checkOutput("fwd_a_mem_prio", {30'b0, forward_a}, 32'h1);
    checkOutput("fwd_b_none", {30'b0, forward_b}, 32'h0);
    mem_rd = 8; #1;
    checkOutput("fwd_a_wb", {30'b0, forward_a}, 32'h2);
    ex_use_rs1 = 0; #1;
    checkOutput("fwd_a_unused", {30'b0, forward_a}, 32'h0);
    ex_use_rs1 = 1; ex_rs1 = 0; mem_rd = 0; wb_rd = 0; #1;
    checkOutput("fwd_a_x0", {30'b0, forward_a}, 32'h0);
    mem_rd = 6; wb_rd = 6; #1;
    checkOutput("fwd_b_mem", {30'b0, forward_b}, 32'h1);
    mem_regwrite = 0; #1;
    checkOutput("fwd_b_wb", {30'b0, forward_b}, 32'h2);
    wb_valid = 0; #1;
    checkOutput("fwd_b_wb_invalid", {30'b0, forward_b}, 32'h0);
    step();
    clearInputs();

    // EX load-use and scoreboard hand-off
    $display("[TB] load-use");
    ex_valid = 1; ex_long = 1; ex_regwrite = 1; ex_rd = 7; ex_adv = 1;
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 7;
    #1;
    checkOutput("ex_load_use_stall", {31'b0, stall_id}, 32'h1);
    id_use_rs2 = 0; #1;
    checkOutput("ex_load_rs2_unused", {31'b0, stall_id}, 32'h0);
    id_use_rs2 = 1;
    step();
    ex_valid = 0; ex_long = 0; ex_regwrite = 0; ex_rd = 0; ex_adv = 0;
    #1;
    checkOutput("pending7_set", pending_mask, 32'h80);
    checkOutput("pending7_stall", {31'b0, stall_id}, 32'h1);
    lr_valid = 1; lr_rd = 7; #1;
    checkOutput("return_bypass_stall", {31'b0, stall_id}, 32'h0);
    step();
    lr_valid = 0; #1;
    checkOutput("pending7_cleared", pending_mask, 32'h0);
    clearInputs();

    // Fill the scoreboard
    $display("[TB] scoreboard full");
    applyStimulus(5'd1, 1'b0);
    applyStimulus(5'd2, 1'b0);
    applyStimulus(5'd3, 1'b0);
    checkOutput("three_not_full", {31'b0, sb_full}, 32'h0);
    applyStimulus(5'd4, 1'b0);
    checkOutput("four_pending", pending_mask, 32'h1E);
    checkOutput("four_full", {31'b0, sb_full}, 32'h1);
    id_valid = 1; id_long = 1; id_regwrite = 1; id_rd = 9; #1;
    checkOutput("full_long_stall", {31'b0, stall_id}, 32'h1);
    lr_valid = 1; lr_rd = 2; #1;
    checkOutput("full_still_stall", {31'b0, stall_id}, 32'h1);
    step();
    lr_valid = 0; #1;
    checkOutput("full_dropped", {31'b0, sb_full}, 32'h0);
    checkOutput("after_return2", pending_mask, 32'h1A);
    checkOutput("full_stall_released", {31'b0, stall_id}, 32'h0);
    clearInputs();
    lr_valid = 1; lr_rd = 9; step();
    lr_rd = 0; step();
    lr_valid = 0; #1;
    checkOutput("ignored_returns", pending_mask, 32'h1A);
    applyStimulus(5'd9, 1'b0);
    checkOutput("refill_pending", pending_mask, 32'h21A);
    checkOutput("refill_full", {31'b0, sb_full}, 32'h1);

    // WAW on a pending destination
    $display("[TB] waw");
    id_valid = 1; id_regwrite = 1; id_rd = 3; #1;
    checkOutput("waw_stall", {31'b0, stall_id}, 32'h1);
    step(); step(); #1;
    checkOutput("waw_stall_held", {31'b0, stall_id}, 32'h1);
    lr_valid = 1; lr_rd = 3; #1;
    checkOutput("waw_release", {31'b0, stall_id}, 32'h0);
    step();
    lr_valid = 0; #1;
    checkOutput("waw_pending", pending_mask, 32'h212);
    checkOutput("waw_not_full", {31'b0, sb_full}, 32'h0);
    clearInputs();
    lr_valid = 1; lr_rd = 1; step();
    lr_rd = 4; step();
    lr_rd = 9; step();
    lr_valid = 0; #1;
    checkOutput("drained", pending_mask, 32'h0);

    // Flush, x0 issue and same-cycle issue/return
    $display("[TB] flush and same-cycle");
    applyStimulus(5'd6, 1'b1);
    checkOutput("flush_no_set", pending_mask, 32'h0);
    applyStimulus(5'd0, 1'b0);
    checkOutput("x0_never_pending", pending_mask, 32'h0);
    applyStimulus(5'd6, 1'b0);
    checkOutput("issue6", pending_mask, 32'h40);
    lr_valid = 1; lr_rd = 6;
    applyStimulus(5'd6, 1'b0);
    lr_valid = 0; lr_rd = 0; #1;
    checkOutput("same_cycle_bit", pending_mask, 32'h40);
    applyStimulus(5'd1, 1'b0);
    applyStimulus(5'd2, 1'b0);
    checkOutput("same_cycle_count3", {31'b0, sb_full}, 32'h0);
    applyStimulus(5'd3, 1'b0);
    checkOutput("same_cycle_count4", {31'b0, sb_full}, 32'h1);
    checkOutput("same_cycle_mask", pending_mask, 32'h4E);

    // Stall timeout and mid-stall reset
    $display("[TB] timeout");
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 3; #1;
    checkOutput("timeout_stall_on", {31'b0, stall_id}, 32'h1);
    repeat (255) step();
    #1;
    checkOutput("timeout_255", {31'b0, timeout_err}, 32'h0);
    step(); #1;
    checkOutput("timeout_256", {31'b0, timeout_err}, 32'h1);
    repeat (3) step();
    #1;
    checkOutput("timeout_sat", {31'b0, timeout_err}, 32'h1);
    id_valid = 0; step(); step(); #1;
    checkOutput("timeout_sticky", {31'b0, timeout_err}, 32'h1);
    id_valid = 1; step();
    rst = 1; #1;
    checkOutput("rst_pending", pending_mask, 32'h0);
    checkOutput("rst_sb_full", {31'b0, sb_full}, 32'h0);
    checkOutput("rst_timeout", {31'b0, timeout_err}, 32'h0);
    checkOutput("rst_stall", {31'b0, stall_id}, 32'h0);
    rst = 0;
    clearInputs();
    lr_valid = 1; lr_rd = 3; step();
    lr_valid = 0; #1;
    checkOutput("late_return_ignored", pending_mask, 32'h0);
    applyStimulus(5'd1, 1'b0);
    applyStimulus(5'd2, 1'b0);
    applyStimulus(5'd3, 1'b0);
    checkOutput("post_rst_count3", {31'b0, sb_full}, 32'h0);
    applyStimulus(5'd4, 1'b0);
    checkOutput("post_rst_count4", {31'b0, sb_full}, 32'h1);

    // Perf counters over a three-cycle stall with MEM forwarding
    $display("[TB] perf");
    rst = 1; #1;
    rst = 0;
    clearInputs();
    ex_valid = 1; ex_use_rs1 = 1; ex_rs1 = 5; ex_long = 1; ex_regwrite = 1; ex_rd = 7;
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 7;
    #1;
    checkOutput("perf_window_stall", {31'b0, stall_id}, 32'h1);
    checkOutput("perf_window_fwd", {30'b0, forward_a}, 32'h1);
    repeat (3) step();
    clearInputs(); #1;
`ifdef HAZARD_PERF_EN
    checkOutput("perf_stall_cycles", perf_stall_cycles, 32'd3);
    checkOutput("perf_fwd_events", perf_fwd_events, 32'd3);
`else
    checkOutput("perf_stall_tied", perf_stall_cycles, 32'd0);
    checkOutput("perf_fwd_tied", perf_fwd_events, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
